// File: rtl/xlr8_xb_fifo_bridge.sv
// xlr8_xb_fifo_bridge: CPU data-memory mapped bridge between the AVR data bus
// and a pair of valid/ready byte streams (TX towards user logic, RX from it).
// Four registers: CTRL, STAT, TXD (push TX), RXD (pop RX).

// Small synchronous FIFO with a combinational head read. The caller gates
// push with !full and pop with !empty; flush wins over both.
module xlr8_xb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Storage: contents need no reset, validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

module xlr8_xb_fifo_bridge #(
  parameter int CTRL_ADDR = 0,
  parameter int STAT_ADDR = 1,
  parameter int TXD_ADDR  = 2,
  parameter int RXD_ADDR  = 3,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clken,
  input  logic [7:0]       ramadr,
  input  logic             dm_sel,
  input  logic             ramre,
  input  logic             ramwe,
  input  logic [7:0]       dbus_in,
  output logic [7:0]       dbus_out,
  output logic             io_out_en,
  output logic             tx_valid,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_ready,
  input  logic             rx_valid,
  input  logic [WIDTH-1:0] rx_data,
  output logic             rx_ready,
  output logic             xb_enable,
  output logic             irq
);

  localparam logic [7:0] CTRL_A = 8'(CTRL_ADDR);
  localparam logic [7:0] STAT_A = 8'(STAT_ADDR);
  localparam logic [7:0] TXD_A  = 8'(TXD_ADDR);
  localparam logic [7:0] RXD_A  = 8'(RXD_ADDR);

  logic sel_ctrl, sel_stat, sel_txd, sel_rxd;
  logic we_ctrl, we_stat, we_txd;
  logic re_rxd;
  logic enable, tx_irq_en, rx_irq_en;
  logic tx_ovf, rx_udf;
  logic flush;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic [WIDTH-1:0] tx_head, rx_head;
  logic [7:0] stat;

  assign sel_ctrl = dm_sel && (ramadr == CTRL_A);
  assign sel_stat = dm_sel && (ramadr == STAT_A);
  assign sel_txd  = dm_sel && (ramadr == TXD_A);
  assign sel_rxd  = dm_sel && (ramadr == RXD_A);

  assign we_ctrl = sel_ctrl && ramwe && clken;
  assign we_stat = sel_stat && ramwe && clken;
  assign we_txd  = sel_txd  && ramwe && clken;
  assign re_rxd  = sel_rxd  && ramre && clken;

  // Flush is a write strobe only; it is never stored so CTRL[3] reads 0
  assign flush = we_ctrl && dbus_in[3];

  // A TXD write into a full FIFO is dropped even if the stream pops this cycle
  assign tx_push = we_txd && !tx_full;
  assign tx_pop  = tx_valid && tx_ready;
  assign rx_push = rx_valid && rx_ready;
  assign rx_pop  = re_rxd && !rx_empty;

  assign tx_valid  = enable && !tx_empty;
  assign tx_data   = tx_head;
  assign rx_ready  = enable && !rx_full;
  assign xb_enable = enable;

  assign io_out_en = (sel_ctrl || sel_stat || sel_txd || sel_rxd) && ramre;

  assign stat = {2'b00, rx_udf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};

  xlr8_xb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (dbus_in[WIDTH-1:0]),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  xlr8_xb_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  // Control register: enable and the two interrupt enables
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      enable    <= 1'b0;
      tx_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
    end else if (we_ctrl) begin
      enable    <= dbus_in[0];
      tx_irq_en <= dbus_in[1];
      rx_irq_en <= dbus_in[2];
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (we_txd && tx_full)            tx_ovf <= 1'b1;
      else if (we_stat && dbus_in[4])   tx_ovf <= 1'b0;
      if (re_rxd && rx_empty)           rx_udf <= 1'b1;
      else if (we_stat && dbus_in[5])   rx_udf <= 1'b0;
    end
  end

  // Level interrupt, registered one cycle behind its condition
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) irq <= 1'b0;
    else       irq <= (tx_irq_en && tx_empty) || (rx_irq_en && !rx_empty);
  end

  // Read mux; TXD and unselected addresses return zero
  always_comb begin
    dbus_out = 8'h00;
    if (sel_ctrl)      dbus_out = {5'b00000, rx_irq_en, tx_irq_en, enable};
    else if (sel_stat) dbus_out = stat;
    else if (sel_rxd)  dbus_out = rx_empty ? 8'h00 : 8'(rx_head);
  end

endmodule

// File: tb/tb_xlr8_xb_fifo_bridge.sv
// Self-checking bench for xlr8_xb_fifo_bridge: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_xlr8_xb_fifo_bridge;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [7:0] A_CTRL = 8'd0;
  localparam logic [7:0] A_STAT = 8'd1;
  localparam logic [7:0] A_TXD  = 8'd2;
  localparam logic [7:0] A_RXD  = 8'd3;
  localparam logic [7:0] A_NONE = 8'h40;

  logic             clk = 1'b0;
  logic             rstn;
  logic             clken;
  logic [7:0]       ramadr;
  logic             dm_sel, ramre, ramwe;
  logic [7:0]       dbus_in, dbus_out;
  logic             io_out_en;
  logic             tx_valid, tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             rx_valid, rx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             xb_enable, irq;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] tx_q[$];
  logic [WIDTH-1:0] rx_q[$];
  logic m_en, m_txie, m_rxie, m_ovf, m_udf, m_irq;

  // Background stream inputs used by the helper tasks
  logic             bg_txr = 1'b0;
  logic             bg_rxv = 1'b0;
  logic [WIDTH-1:0] bg_rxd = '0;

  always #5 clk = ~clk;

  xlr8_xb_fifo_bridge #(
    .CTRL_ADDR(0), .STAT_ADDR(1), .TXD_ADDR(2), .RXD_ADDR(3),
    .WIDTH(WIDTH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .clken(clken), .ramadr(ramadr), .dm_sel(dm_sel),
    .ramre(ramre), .ramwe(ramwe), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .io_out_en(io_out_en), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .xb_enable(xb_enable), .irq(irq)
  );

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_stat();
    return {2'b00, m_udf, m_ovf, rx_q.size() == 0, rx_q.size() == DEPTH,
            tx_q.size() == 0, tx_q.size() == DEPTH};
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      A_CTRL:  return {5'b00000, m_rxie, m_txie, m_en};
      A_STAT:  return m_stat();
      A_RXD:   return (rx_q.size() != 0) ? 8'(rx_q[0]) : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    {m_en, m_txie, m_rxie, m_ovf, m_udf, m_irq} = '0;
  endtask

  // Compare every visible output against the model for the current inputs
  task automatic check_comb();
    logic hit;
    hit = dm_sel && (ramadr <= 8'd3);
    chk1("io_out_en", io_out_en, hit && ramre);
    if (ramre || !hit) chk("dbus_out", dbus_out, hit ? m_read(ramadr) : 8'h00);
    chk1("tx_valid", tx_valid, m_en && (tx_q.size() != 0));
    if (m_en && (tx_q.size() != 0)) chk("tx_data", 8'(tx_data), 8'(tx_q[0]));
    chk1("rx_ready", rx_ready, m_en && (rx_q.size() < DEPTH));
    chk1("xb_enable", xb_enable, m_en);
    chk1("irq", irq, m_irq);
  endtask

  task automatic apply(input logic s, input logic [7:0] a, input logic r, input logic w,
                       input logic [7:0] d, input logic ce, input logic txr,
                       input logic rxv, input logic [WIDTH-1:0] rxd);
    dm_sel = s; ramadr = a; ramre = r; ramwe = w; dbus_in = d; clken = ce;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    #2;
    check_comb();
  endtask

  // Advance the model by the rules for one clock edge, then clock the DUT
  task automatic tick();
    logic acc, we_c, we_s, we_t, re_r, txv, txfull, rxrdy, rxempty, irq_n;
    acc     = dm_sel && clken;
    we_c    = acc && ramwe && (ramadr == A_CTRL);
    we_s    = acc && ramwe && (ramadr == A_STAT);
    we_t    = acc && ramwe && (ramadr == A_TXD);
    re_r    = acc && ramre && (ramadr == A_RXD);
    txv     = m_en && (tx_q.size() != 0);
    txfull  = (tx_q.size() == DEPTH);
    rxrdy   = m_en && (rx_q.size() < DEPTH);
    rxempty = (rx_q.size() == 0);
    irq_n   = (m_txie && (tx_q.size() == 0)) || (m_rxie && !rxempty);
    if (we_s && dbus_in[4]) m_ovf = 1'b0;
    if (we_s && dbus_in[5]) m_udf = 1'b0;
    if (we_t && txfull)  m_ovf = 1'b1;
    if (re_r && rxempty) m_udf = 1'b1;
    if (we_c && dbus_in[3]) begin
      tx_q.delete();
      rx_q.delete();
    end else begin
      if (txv && tx_ready) void'(tx_q.pop_front());
      if (we_t && !txfull) tx_q.push_back(dbus_in[WIDTH-1:0]);
      if (re_r && !rxempty) void'(rx_q.pop_front());
      if (rx_valid && rxrdy) rx_q.push_back(rx_data);
    end
    if (we_c) {m_rxie, m_txie, m_en} = dbus_in[2:0];
    m_irq = irq_n;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    apply(1'b1, a, 1'b0, 1'b1, d, 1'b1, bg_txr, bg_rxv, bg_rxd);
    tick();
  endtask

  task automatic rdx(input logic [7:0] a, input logic [7:0] exp, input string tag);
    apply(1'b1, a, 1'b1, 1'b0, 8'h00, 1'b1, bg_txr, bg_rxv, bg_rxd);
    chk(tag, dbus_out, exp);
    tick();
  endtask

  task automatic idle();
    apply(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, bg_txr, bg_rxv, bg_rxd);
    tick();
  endtask

  initial begin
    model_reset();
    rstn = 1'b0;

    // Reset state, read while reset is held
    apply(1'b1, A_STAT, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    chk("rst_stat", dbus_out, 8'h0A);
    chk1("rst_io_out_en", io_out_en, 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rdx(A_CTRL, 8'h00, "rst_ctrl");
    rdx(A_TXD, 8'h00, "txd_read_zero");

    // TX overflow, then drain the stream in order
    wr(A_CTRL, 8'h01);
    for (int i = 1; i <= 5; i++) wr(A_TXD, 8'(8'h11 * i));
    rdx(A_STAT, 8'h19, "tx_full_ovf");
    bg_txr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      apply(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, bg_txr, bg_rxv, bg_rxd);
      chk("tx_stream", 8'(tx_data), 8'(8'h11 * i));
      chk1("tx_stream_valid", tx_valid, 1'b1);
      tick();
    end
    apply(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, bg_txr, bg_rxv, bg_rxd);
    chk1("tx_drained", tx_valid, 1'b0);
    tick();
    bg_txr = 1'b0;
    wr(A_STAT, 8'h10);
    rdx(A_STAT, 8'h0A, "tx_ovf_clear");

    // RX reads and underflow
    bg_rxv = 1'b1; bg_rxd = 8'hA5; idle();
    bg_rxd = 8'h5A; idle();
    bg_rxv = 1'b0;
    rdx(A_RXD, 8'hA5, "rx_first");
    rdx(A_RXD, 8'h5A, "rx_second");
    rdx(A_RXD, 8'h00, "rx_udf_read");
    rdx(A_STAT, 8'h2A, "rx_udf_stat");
    wr(A_STAT, 8'h20);
    rdx(A_STAT, 8'h0A, "rx_udf_clear");

    // Pointer wrap with simultaneous push and pop at count 2
    bg_rxv = 1'b1; bg_rxd = 8'd1; idle();
    bg_rxd = 8'd2; idle();
    for (int i = 0; i < 10; i++) begin
      bg_rxd = 8'(3 + i);
      apply(1'b1, A_RXD, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, bg_rxd);
      chk("rx_wrap", dbus_out, 8'(1 + i));
      tick();
    end
    bg_rxv = 1'b0;
    rdx(A_STAT, 8'h02, "rx_count2");
    bg_rxv = 1'b1; bg_rxd = 8'd13; idle();
    bg_rxd = 8'd14; idle();
    bg_rxd = 8'hEE; idle();
    bg_rxv = 1'b0;
    rdx(A_STAT, 8'h06, "rx_full");
    for (int i = 11; i <= 14; i++) rdx(A_RXD, 8'(i), "rx_drain");

    // Flush with data in both directions
    bg_rxv = 1'b1; bg_rxd = 8'h66; idle();
    bg_rxv = 1'b0;
    wr(A_TXD, 8'hA1); wr(A_TXD, 8'hA2); wr(A_TXD, 8'hA3);
    wr(A_CTRL, 8'h09);
    apply(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    chk1("flush_tx_valid", tx_valid, 1'b0);
    tick();
    rdx(A_STAT, 8'h0A, "flush_stat");
    rdx(A_CTRL, 8'h01, "flush_ctrl");

    // RX interrupt timing
    wr(A_CTRL, 8'h05);
    bg_rxv = 1'b1; bg_rxd = 8'h77; idle();
    bg_rxv = 1'b0;
    apply(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    chk1("irq_lag", irq, 1'b0);
    tick();
    apply(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    chk1("irq_rise", irq, 1'b1);
    tick();
    rdx(A_RXD, 8'h77, "irq_rx_read");
    apply(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    chk1("irq_hold", irq, 1'b1);
    tick();
    apply(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    chk1("irq_fall", irq, 1'b0);
    tick();

    // Disabled bridge: CPU side still works, streams are blocked
    wr(A_CTRL, 8'h00);
    wr(A_TXD, 8'h3C);
    bg_rxv = 1'b1; bg_rxd = 8'h99; idle();
    bg_rxv = 1'b0;
    rdx(A_STAT, 8'h08, "disabled_stat");
    wr(A_CTRL, 8'h08);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic s, r, w, ce, txr, rxv;
      logic [7:0] a, d;
      int k;
      s   = ($urandom_range(0, 7) != 0);
      k   = $urandom_range(0, 4);
      a   = (k == 4) ? A_NONE : 8'(k);
      r   = ($urandom_range(0, 1) != 0);
      w   = ($urandom_range(0, 1) != 0);
      d   = 8'($urandom);
      if (a == A_CTRL) begin
        d[0] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) != 0) d[3] = 1'b0;
      end
      ce  = ($urandom_range(0, 3) != 0);
      txr = ($urandom_range(0, 2) == 0);
      rxv = ($urandom_range(0, 1) != 0);
      apply(s, a, r, w, d, ce, txr, rxv, WIDTH'($urandom));
      tick();
    end

    // Asynchronous reset mid-transfer while clken is low
    wr(A_CTRL, 8'h05);
    wr(A_TXD, 8'h3C);
    bg_rxv = 1'b1; bg_rxd = 8'h42; idle();
    bg_rxv = 1'b0;
    idle();
    apply(1'b1, A_STAT, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    chk1("pre_rst_irq", irq, 1'b1);
    rstn = 1'b0;
    #1;
    chk("arst_stat", dbus_out, 8'h0A);
    chk1("arst_tx_valid", tx_valid, 1'b0);
    chk1("arst_rx_ready", rx_ready, 1'b0);
    chk1("arst_irq", irq, 1'b0);
    chk1("arst_enable", xb_enable, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    idle();
    rdx(A_RXD, 8'h00, "arst_rx_empty");
    rdx(A_STAT, 8'h2A, "arst_stat_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xlr8_xb_fifo_bridge.md
XLR8_XB_FIFO_BRIDGE -- requirements
Module: xlr8_xb_fifo_bridge

Interface
REQ-001 Parameter CTRL_ADDR, default 0, DM address of the control register (R/W).
REQ-002 Parameter STAT_ADDR, default 1, DM address of the status register (read; write-1-to-clear sticky bits).
REQ-003 Parameter TXD_ADDR, default 2, DM address of the TX data port (write-only; pushes the TX FIFO).
REQ-004 Parameter RXD_ADDR, default 3, DM address of the RX data port (read-only; pops the RX FIFO).
REQ-005 Parameter WIDTH, default 8, data width, legal range 1..8.
REQ-006 Parameter DEPTH, default 4, FIFO depth per direction, power of 2, legal range 2..64.
REQ-007 clk  in  1  clock; all state updates on its rising edge.
REQ-008 rstn  in  1  asynchronous, active-low reset.
REQ-009 clken  in  1  clock enable; qualifies CPU-side accesses only.
REQ-010 ramadr  in  8  DM address; dm_sel  in  1  DM select; ramre  in  1  read enable; ramwe  in  1  write enable.
REQ-011 dbus_in  in  8  write data; dbus_out  out  8  read data; io_out_en  out  1  read-data valid.
REQ-012 tx_valid  out  1; tx_data  out  WIDTH; tx_ready  in  1: TX stream towards the user logic.
REQ-013 rx_valid  in  1; rx_data  in  WIDTH; rx_ready  out  1: RX stream from the user logic.
REQ-014 xb_enable  out  1  mirror of CTRL[0]; irq  out  1  interrupt request, level, active-high.

Function
REQ-015 Register select: sel_X = dm_sel && ramadr==X_ADDR; we_X = sel_X && ramwe && clken; re_X = sel_X && ramre && clken.
REQ-016 io_out_en SHALL be the combinational OR of all four read selects (sel_X && ramre).
REQ-017 dbus_out SHALL return 0 when no register is selected; all read data is zero-extended to 8 bits.
REQ-018 CTRL bits: [0] enable, [1] tx_irq_en, [2] rx_irq_en, [3] flush (write-only, self-clearing, reads 0); [7:4] read 0.
REQ-019 STAT bits: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_ovf (sticky), [5] rx_udf (sticky), [7:6] read 0.
REQ-020 A STAT write with bit 4 and/or bit 5 set SHALL clear the corresponding sticky flag on the next edge.
REQ-021 Each FIFO SHALL hold DEPTH entries with log2(DEPTH)-bit wrapping pointers and a log2(DEPTH)+1-bit count; full when count==DEPTH, empty when count==0.
REQ-022 we_TXD while TX is not full SHALL push dbus_in[WIDTH-1:0]; while TX is full the write is dropped and tx_ovf is set, even if a pop occurs in the same cycle.
REQ-023 A TXD read SHALL return 0 with no side effect.
REQ-024 tx_valid = enable && !tx_empty; tx_data = TX head entry; a pop occurs when tx_valid && tx_ready.
REQ-025 rx_ready = enable && !rx_full; a push of rx_data occurs when rx_valid && rx_ready.
REQ-026 An RXD read SHALL return the RX head combinationally and pop on re_RXD; on an empty FIFO it returns 0, sets rx_udf and leaves the pointers unchanged.
REQ-027 A push and a pop in the same cycle on a non-full, non-empty FIFO SHALL both take effect, leaving count unchanged.
REQ-028 A flush write SHALL empty both FIFOs on the next edge, with priority over any push or pop in that cycle; sticky flags are unaffected.
REQ-029 irq SHALL be registered, one cycle after the condition (tx_irq_en && tx_empty) || (rx_irq_en && !rx_empty).
REQ-030 With enable=0, CPU-side accesses SHALL still function; only the user-side handshakes are blocked.

Reset
REQ-031 While rstn=0: CTRL=0; both FIFOs empty; sticky flags 0; irq=0; tx_valid=0; rx_ready=0; STAT reads 0x0A.
REQ-032 An assertion of rstn mid-transfer SHALL discard all FIFO contents immediately, independent of clken.

Verification
REQ-033 After reset, read STAT -> 0x0A, io_out_en=1 during the read; read CTRL -> 0x00.
REQ-034 With enable=1 and tx_ready=0, write 0x11,0x22,0x33,0x44,0x55 to TXD -> STAT bit0=1 and bit4=1; with tx_ready=1, the stream delivers 0x11..0x44 in order, then tx_valid=0.
REQ-035 Drive rx_valid with 0xA5 then 0x5A -> RXD reads return 0xA5, 0x5A; a third read returns 0x00 with STAT bit5=1; writing 0x20 to STAT clears bit5.
REQ-036 With DEPTH=4, run 10 push/pop cycles on the RX FIFO so the pointers wrap -> data stays in order and the count stays consistent; a simultaneous push and pop at count 2 leaves the count at 2.
REQ-037 Fill TX with 3 entries and write CTRL=0x09 -> the next cycle tx_valid=0 and STAT bit1=1; CTRL reads 0x01.
REQ-038 Write CTRL=0x05 and push one RX entry -> irq rises one cycle after rx_empty falls and falls one cycle after the RXD read drains the FIFO.
